// File: rtl/dcache_miss_ctrl.sv
// Miss/refill controller for the 4-way data cache: stalls on a miss, writes back a
// dirty victim as beats, refills the missing block as beats, then strobes allocation.
module dcache_miss_ctrl #(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64,
    parameter int SET_WIDTH  = 512
) (
    input  logic                  clk_i,
    input  logic                  arst_i,
    input  logic                  mem_access_i,
    input  logic                  hit_i,
    input  logic                  dirty_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [ADDR_WIDTH-1:0] addr_wb_i,
    input  logic [SET_WIDTH-1:0]  data_block_i,
    output logic                  stall_o,
    output logic                  block_we_o,
    output logic [SET_WIDTH-1:0]  data_block_o,
    output logic                  mem_valid_o,
    output logic                  mem_we_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    input  logic                  mem_ready_i,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i
);
    localparam int BEAT_COUNT  = SET_WIDTH / DATA_WIDTH;
    localparam int CNT_WIDTH   = $clog2(BEAT_COUNT);
    localparam int BEAT_SHIFT  = $clog2(DATA_WIDTH / 8);
    localparam int BLOCK_BYTES = SET_WIDTH / 8;
    localparam logic [ADDR_WIDTH-1:0] BLOCK_MASK = ADDR_WIDTH'(BLOCK_BYTES - 1);
    localparam logic [CNT_WIDTH-1:0]  LAST_BEAT  = CNT_WIDTH'(BEAT_COUNT - 1);

    typedef enum logic [1:0] {IDLE, WRITEBACK, REFILL, ALLOCATE} state_t;

    state_t                state;
    state_t                state_next;
    logic [CNT_WIDTH-1:0]  cnt;
    logic [SET_WIDTH-1:0]  buffer;
    logic [ADDR_WIDTH-1:0] wb_base;
    logic [ADDR_WIDTH-1:0] rf_base;
    logic [ADDR_WIDTH-1:0] beat_offset;
    logic                  miss;
    logic                  beat_done;
    logic                  last_beat;

    assign miss         = mem_access_i & ~hit_i;
    assign beat_offset  = ADDR_WIDTH'(cnt) << BEAT_SHIFT;
    assign beat_done    = mem_ready_i & ((state == WRITEBACK) | (state == REFILL));
    assign last_beat    = (cnt == LAST_BEAT);
    assign data_block_o = buffer;

    // NOTE: every output and next-state gets a default first, so no latch is inferred.
    always_comb begin
        state_next  = state;
        stall_o     = 1'b0;
        block_we_o  = 1'b0;
        mem_valid_o = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        case (state)
            IDLE: begin
                // Held low while reset is applied so every output reads 0 during reset.
                stall_o = miss & ~arst_i;
                if (miss) begin
                    state_next = dirty_i ? WRITEBACK : REFILL;
                end
            end
            WRITEBACK: begin
                stall_o     = 1'b1;
                mem_valid_o = 1'b1;
                mem_we_o    = 1'b1;
                mem_addr_o  = wb_base + beat_offset;
                mem_wdata_o = buffer[int'(cnt)*DATA_WIDTH +: DATA_WIDTH];
                if (mem_ready_i && last_beat) begin
                    state_next = REFILL;
                end
            end
            REFILL: begin
                stall_o     = 1'b1;
                mem_valid_o = 1'b1;
                mem_addr_o  = rf_base + beat_offset;
                if (mem_ready_i && last_beat) begin
                    state_next = ALLOCATE;
                end
            end
            ALLOCATE: begin
                stall_o    = 1'b1;
                block_we_o = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: the block buffer is plain flops, not a RAM, so it can be cleared by reset and
    // data_block_o reads 0 afterwards. Sequential state uses non-blocking assignments only.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state   <= IDLE;
            cnt     <= '0;
            buffer  <= '0;
            wb_base <= '0;
            rf_base <= '0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (miss) begin
                        buffer  <= data_block_i;
                        wb_base <= addr_wb_i;
                        rf_base <= addr_i & ~BLOCK_MASK;
                        cnt     <= '0;
                    end
                end
                WRITEBACK: begin
                    if (beat_done) begin
                        cnt <= last_beat ? '0 : cnt + 1'b1;
                    end
                end
                REFILL: begin
                    // The victim has already been written out, so its storage takes the refill.
                    if (beat_done) begin
                        buffer[int'(cnt)*DATA_WIDTH +: DATA_WIDTH] <= mem_rdata_i;
                        cnt <= last_beat ? '0 : cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dcache_miss_ctrl.sv
// Scoreboard bench for dcache_miss_ctrl: a transaction-level model queues the expected
// beats and refill blocks; a negedge monitor compares them against what the DUT presents.
module tb_dcache_miss_ctrl;
    logic         clk = 1'b0;
    logic         arst_i;
    logic         mem_access_i, hit_i, dirty_i;
    logic [63:0]  addr_i, addr_wb_i;
    logic [511:0] data_block_i;
    logic         stall_o, block_we_o;
    logic [511:0] data_block_o;
    logic         mem_valid_o, mem_we_o;
    logic [63:0]  mem_addr_o, mem_wdata_o;
    logic         mem_ready_i;
    logic [63:0]  mem_rdata_i;

    typedef struct packed {
        logic        we;
        logic [63:0] addr;
        logic [63:0] wdata;
    } beat_t;

    beat_t        beat_q[$];
    logic [511:0] blk_q[$];
    int           tests = 0;
    int           fails = 0;
    int           rd_mode = 0;

    dcache_miss_ctrl dut (
        .clk_i(clk), .arst_i(arst_i), .mem_access_i(mem_access_i), .hit_i(hit_i),
        .dirty_i(dirty_i), .addr_i(addr_i), .addr_wb_i(addr_wb_i),
        .data_block_i(data_block_i), .stall_o(stall_o), .block_we_o(block_we_o),
        .data_block_o(data_block_o), .mem_valid_o(mem_valid_o), .mem_we_o(mem_we_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_ready_i(mem_ready_i),
        .mem_rdata_i(mem_rdata_i)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Memory contents as seen by refill reads.
    function automatic logic [63:0] mem_word(input logic [63:0] a);
        if (rd_mode == 0) return 64'h1111_1111_1111_1111 * ((a >> 3) & 64'd7);
        return (a * 64'h9E37_79B9_7F4A_7C15) ^ 64'h0123_4567_89AB_CDEF;
    endfunction

    function automatic logic [511:0] rand_block();
        logic [511:0] v;
        for (int k = 0; k < 16; k++) v[32*k +: 32] = $urandom;
        return v;
    endfunction

    // Reference model of one miss: optional 8-beat writeback, 8-beat refill, one block.
    function automatic void push_miss(input logic [63:0] addr, input logic [63:0] wb,
                                      input logic dirty, input logic [511:0] victim);
        logic [63:0]  base;
        logic [511:0] blk;
        base = addr & ~64'h3F;
        if (dirty)
            for (int k = 0; k < 8; k++)
                beat_q.push_back('{we: 1'b1, addr: wb + 64'(8*k), wdata: victim[64*k +: 64]});
        for (int k = 0; k < 8; k++) begin
            beat_q.push_back('{we: 1'b0, addr: base + 64'(8*k), wdata: 64'd0});
            blk[64*k +: 64] = mem_word(base + 64'(8*k));
        end
        blk_q.push_back(blk);
    endfunction

    // Monitor + memory responder, active on the falling edge.
    initial begin
        beat_t       e;
        logic        prev_stalled;
        logic        p_we;
        logic [63:0] p_addr, p_wdata;
        prev_stalled = 1'b0;
        p_we = 1'b0; p_addr = '0; p_wdata = '0;
        forever begin
            @(negedge clk);
            mem_rdata_i = (mem_valid_o && !mem_we_o) ? mem_word(mem_addr_o) : 64'hDEAD_BEEF_DEAD_BEEF;
            if (arst_i) begin
                prev_stalled = 1'b0;
            end else begin
                if (prev_stalled && mem_valid_o) begin
                    check("hold_we", mem_we_o, p_we);
                    check("hold_addr", mem_addr_o, p_addr);
                    check("hold_wdata", mem_wdata_o, p_wdata);
                end
                prev_stalled = mem_valid_o && !mem_ready_i;
                p_we = mem_we_o; p_addr = mem_addr_o; p_wdata = mem_wdata_o;
                if (mem_valid_o && mem_ready_i) begin
                    if (beat_q.size() == 0) begin
                        check("unexpected_beat", 1'b1, 1'b0);
                    end else begin
                        e = beat_q.pop_front();
                        check("beat_we", mem_we_o, e.we);
                        check("beat_addr", mem_addr_o, e.addr);
                        if (e.we) check("beat_wdata", mem_wdata_o, e.wdata);
                    end
                end
                if (block_we_o) begin
                    if (blk_q.size() == 0) check("unexpected_alloc", 1'b1, 1'b0);
                    else check("alloc_block", data_block_o, blk_q.pop_front());
                end
            end
        end
    end

    function automatic logic ready_for(input int mode, input int cyc);
        if (mode == 0) return 1'b1;
        if (mode == 1) return ((cyc + 2) % 3) == 0;
        return 1'($urandom_range(0, 1));
    endfunction

    // Drives one miss from the detect cycle through allocation and the retried hit.
    task automatic run_miss(input logic [63:0] addr, input logic [63:0] wb, input logic dirty,
                            input logic [511:0] victim, input int rmode, input int drop_at,
                            input int exp_alloc);
        int cyc;
        bit seen;
        push_miss(addr, wb, dirty, victim);
        mem_access_i = 1'b1; hit_i = 1'b0; dirty_i = dirty;
        addr_i = addr; addr_wb_i = wb; data_block_i = victim;
        mem_ready_i = ready_for(rmode, 0);
        #1;
        check("stall_detect", stall_o, 1'b1);
        check("valid_detect", mem_valid_o, 1'b0);
        cyc = 0; seen = 0;
        while (!seen && cyc < 400) begin
            @(posedge clk); #1;
            cyc++;
            addr_i = {$urandom, $urandom}; addr_wb_i = {$urandom, $urandom};
            data_block_i = rand_block(); dirty_i = 1'($urandom_range(0, 1));
            if (drop_at >= 0 && cyc >= drop_at) mem_access_i = 1'b0;
            mem_ready_i = ready_for(rmode, cyc);
            #1;
            if (block_we_o) seen = 1;
            else check("stall_busy", stall_o, 1'b1);
        end
        check("alloc_seen", seen, 1'b1);
        if (exp_alloc >= 0) check("alloc_cycle", cyc, exp_alloc);
        check("alloc_stall", stall_o, 1'b1);
        check("alloc_valid", mem_valid_o, 1'b0);
        mem_access_i = 1'b1; hit_i = 1'b1;
        @(posedge clk); #1;
        check("hit_after_stall", stall_o, 1'b0);
        check("alloc_one_cycle", block_we_o, 1'b0);
        check("idle_valid", mem_valid_o, 1'b0);
        check("beats_left", beat_q.size(), 0);
        check("blocks_left", blk_q.size(), 0);
        mem_access_i = 1'b0; hit_i = 1'b0;
    endtask

    initial begin
        logic [511:0] v;
        arst_i = 1'b1; mem_access_i = 1'b0; hit_i = 1'b0; dirty_i = 1'b0;
        addr_i = '0; addr_wb_i = '0; data_block_i = '0; mem_ready_i = 1'b0;
        #1;
        check("rst_stall", stall_o, 1'b0);
        check("rst_block_we", block_we_o, 1'b0);
        check("rst_valid", mem_valid_o, 1'b0);
        check("rst_data_block", data_block_o, 512'd0);
        @(posedge clk); @(posedge clk); #1;
        arst_i = 1'b0;

        // Clean miss with ready tied high.
        rd_mode = 0;
        run_miss(64'h1234_5678, 64'h0, 1'b0, rand_block(), 0, -1, 9);

        // Dirty miss, victim word k = k.
        for (int k = 0; k < 8; k++) v[64*k +: 64] = 64'(k);
        run_miss(64'h0000_1000, 64'h8000_0040, 1'b1, v, 0, -1, 17);

        // Backpressure pattern 1,0,0,1,...
        run_miss(64'h0000_0ABC_DEF0_1234, 64'h40, 1'b1, rand_block(), 1, -1, -1);

        // Hits and idle cycles: nothing happens.
        for (int i = 0; i < 6; i++) begin
            mem_access_i = 1'b1; hit_i = 1'b1; dirty_i = 1'($urandom_range(0, 1));
            addr_i = {$urandom, $urandom}; mem_ready_i = 1'b1;
            #1;
            check("hit_stall", stall_o, 1'b0);
            check("hit_valid", mem_valid_o, 1'b0);
            mem_access_i = 1'b0; hit_i = 1'b0;
            #1;
            check("noacc_stall", stall_o, 1'b0);
            @(posedge clk); #1;
            check("hit_block_we", block_we_o, 1'b0);
        end

        // Reset mid-refill, once beats 0..2 have completed.
        rd_mode = 1;
        push_miss(64'h5555_0000, 64'h0, 1'b0, '0);
        mem_access_i = 1'b1; hit_i = 1'b0; dirty_i = 1'b0;
        addr_i = 64'h5555_0000; mem_ready_i = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        arst_i = 1'b1;
        beat_q.delete(); blk_q.delete();
        #1;
        check("midrst_stall", stall_o, 1'b0);
        check("midrst_valid", mem_valid_o, 1'b0);
        check("midrst_we", mem_we_o, 1'b0);
        check("midrst_addr", mem_addr_o, 64'd0);
        check("midrst_wdata", mem_wdata_o, 64'd0);
        check("midrst_block_we", block_we_o, 1'b0);
        check("midrst_data_block", data_block_o, 512'd0);
        @(posedge clk); #1;
        arst_i = 1'b0; mem_access_i = 1'b0;
        #1;
        check("post_rst_stall", stall_o, 1'b0);
        check("post_rst_valid", mem_valid_o, 1'b0);
        run_miss(64'h7777_00C8, 64'h0, 1'b0, rand_block(), 0, -1, 9);

        // Access dropped during writeback; also wraps the writeback address.
        run_miss(64'h2000_0010, 64'hFFFF_FFFF_FFFF_FFC0, 1'b1, rand_block(), 0, 3, 17);

        // Randomized misses.
        for (int i = 0; i < 12; i++) begin
            run_miss({$urandom, $urandom}, {$urandom, $urandom & 32'hFFFF_FFC0},
                     1'($urandom_range(0, 1)), rand_block(), 2,
                     ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 10)) : -1, -1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/dcache_miss_ctrl.md
Name: dcache_miss_ctrl

Overview:
Miss/refill controller that sits directly beside the 4-way data cache. It detects cache misses and stalls the pipeline. On a dirty victim it writes the 512-bit victim block back to memory as 64-bit beats, then fetches the missing block as 64-bit beats and assembles it. It then pulses the cache's block write enable so the cache allocates the line and the retried access hits.

Parameters:
ADDR_WIDTH, 64, byte address width.
DATA_WIDTH, 64, memory beat width in bits.
SET_WIDTH, 512, cache block width in bits.
BEAT_COUNT, SET_WIDTH/DATA_WIDTH (8), beats per block (derived localparam).

Ports:
clk_i  in  1  clock.
arst_i  in  1  asynchronous active-high reset.
mem_access_i  in  1  load/store present in MEM stage.
hit_i  in  1  cache hit for addr_i.
dirty_i  in  1  PLRU victim is dirty.
addr_i  in  ADDR_WIDTH  access address.
addr_wb_i  in  ADDR_WIDTH  victim block base address.
data_block_i  in  SET_WIDTH  victim block data.
stall_o  out  1  freeze pipeline.
block_we_o  out  1  one-cycle allocate strobe to cache.
data_block_o  out  SET_WIDTH  assembled refill block.
mem_valid_o  out  1  beat request valid.
mem_we_o  out  1  1 = write beat, 0 = read beat.
mem_addr_o  out  ADDR_WIDTH  beat byte address.
mem_wdata_o  out  DATA_WIDTH  write beat data.
mem_ready_i  in  1  beat accepted this cycle.
mem_rdata_i  in  DATA_WIDTH  read data, valid when mem_valid_o & mem_ready_i & ~mem_we_o.

Behaviour:
- States: IDLE, WRITEBACK, REFILL, ALLOCATE. Reset state is IDLE.
- Reset (async, any state): state=IDLE, beat counter=0. All outputs are 0, including data_block_o, which is cleared. An in-flight burst is abandoned.
- IDLE:
  - stall_o = mem_access_i & ~hit_i, combinational, so it is asserted in the same cycle the miss is seen.
  - On a miss, latch the following at that clock edge:
    - victim buffer <= data_block_i;
    - wb_base <= addr_wb_i;
    - rf_base <= {addr_i[ADDR_WIDTH-1:6], 6'b0}.
  - Next state is WRITEBACK if dirty_i, otherwise REFILL. The counter is cleared.
- WRITEBACK:
  - Outputs: mem_valid_o=1, mem_we_o=1, mem_addr_o = wb_base + 8*cnt, mem_wdata_o = victim[64*cnt +: 64].
  - A beat completes on mem_valid_o & mem_ready_i, which increments cnt.
  - When the beat with cnt=BEAT_COUNT-1 completes: go to REFILL and set cnt=0.
- REFILL:
  - Outputs: mem_valid_o=1, mem_we_o=0, mem_addr_o = rf_base + 8*cnt.
  - On a completed beat, buffer[64*cnt +: 64] <= mem_rdata_i and cnt increments.
  - When the last beat completes: go to ALLOCATE.
  - The refill reuses the victim buffer storage; the victim is no longer needed at this point.
- ALLOCATE:
  - block_we_o=1 for exactly one cycle; data_block_o = buffer; stall_o=1.
  - Next state is IDLE. The cache now hits, so stall_o drops in that cycle.
- Handshake:
  - mem_addr_o, mem_we_o and mem_wdata_o stay stable while mem_valid_o=1 & mem_ready_i=0.
  - mem_valid_o stays high across back-to-back beats; with ready tied high, one beat completes per cycle.
  - mem_valid_o=0 in IDLE and ALLOCATE.
- stall_o=1 in WRITEBACK, REFILL and ALLOCATE regardless of mem_access_i. A started transaction always runs to completion; deassertion of mem_access_i does not abort it.
- data_block_o is driven from the buffer at all times; the cache only samples it when block_we_o=1.
- Address arithmetic wraps modulo 2^ADDR_WIDTH. The base is block-aligned, so no carry out of bit 5 occurs.
- Latency with mem_ready_i=1 constantly:
  - clean miss: detect cycle + 8 REFILL + 1 ALLOCATE, with the hit in cycle 10 (counting detect as cycle 0);
  - dirty miss: 8 cycles more.
- Hit in IDLE, or mem_access_i=0: no state change; stall_o=0.

Test Plan:
- Clean miss, ready=1, addr_i=0x1234_5678, dirty_i=0:
  - stall_o=1 in cycle 0;
  - 8 read beats at addresses 0x1234_5640 .. 0x1234_5678, one per cycle;
  - rdata k = 0x1111_1111_1111_1111*k lands in data_block_o[64k+:64];
  - block_we_o pulses once in cycle 9; stall_o=0 in cycle 10 when hit_i=1.
- Dirty miss, addr_wb_i=0x8000_0040, victim word k = k:
  - 8 write beats at 0x8000_0040 + 8k carrying wdata=k;
  - then 8 reads;
  - block_we_o in cycle 17.
- Backpressure: mem_ready_i toggles 1,0,0,1,… during refill. Addr/we stay stable on stalled cycles; exactly 8 beats complete; no beat is lost or duplicated.
- Hit: mem_access_i=1, hit_i=1 → stall_o=0, mem_valid_o=0, block_we_o never asserted. mem_access_i=0 with hit_i=0 → stall_o=0.
- arst_i pulsed mid-REFILL at beat 3:
  - all outputs 0 immediately; state is IDLE;
  - a subsequent miss restarts at beat 0 with the correct base address.
- mem_access_i dropped during WRITEBACK → the burst still completes all 16 beats and ALLOCATE still pulses.
